// File: rtl/reset_seq.sv
// Board reset sequencer: syncs/debounces USER_BTN and stretches the core reset after power-up and release.
// Optional debouncer enabled by defining RESET_SEQ_DEBOUNCE_EN; otherwise btn_db is the synchronised pin.
module reset_seq #(
    parameter int DBNC_CYCLES = 65536,
    parameter int HOLD_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       rst_out,
    output logic       btn_db,
    output logic [7:0] press_cnt
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        PRESSED
    } state_t;

    state_t         state;
    logic [HCW-1:0] hc;
    logic           sync_1;
    logic           btn_db_q;

    if (DBNC_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_param_check
        $error("reset_seq: DBNC_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) sync_1 <= 1'b0;
        else        sync_1 <= ~btn;
    end

`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam int DCW = $clog2(DBNC_CYCLES);

    logic           btn_s;
    logic [DCW-1:0] dc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s  <= 1'b0;
            dc     <= '0;
            btn_db <= 1'b0;
        end else begin
            btn_s <= sync_1;
            if (btn_s == btn_db) begin
                dc <= '0;
            end else if (dc == DCW'(DBNC_CYCLES - 1)) begin
                btn_db <= btn_s;
                dc     <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end
`else
    // Without the debouncer the output flop doubles as the second synchroniser stage.
    always_ff @(posedge clk) begin
        if (!reset) btn_db <= 1'b0;
        else        btn_db <= sync_1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_db_q  <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_db && !btn_db_q) press_cnt <= press_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= HOLD;
            hc      <= '0;
            rst_out <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (btn_db) begin
                        state   <= PRESSED;
                        rst_out <= 1'b1;
                    end else if (hc == HCW'(HOLD_CYCLES - 1)) begin
                        state   <= RUN;
                        hc      <= '0;
                        rst_out <= 1'b0;
                    end else begin
                        hc      <= hc + 1'b1;
                        rst_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (btn_db) begin
                        state   <= PRESSED;
                        rst_out <= 1'b1;
                    end else begin
                        rst_out <= 1'b0;
                    end
                end
                PRESSED: begin
                    // The edge leaving PRESSED is the first of the HOLD_CYCLES stretch.
                    if (!btn_db) begin
                        if (HOLD_CYCLES == 1) begin
                            state   <= RUN;
                            hc      <= '0;
                            rst_out <= 1'b0;
                        end else begin
                            state   <= HOLD;
                            hc      <= HCW'(1);
                            rst_out <= 1'b1;
                        end
                    end else begin
                        hc      <= '0;
                        rst_out <= 1'b1;
                    end
                end
                default: begin
                    state   <= HOLD;
                    hc      <= '0;
                    rst_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_seq.md
# reset_seq

Board-level reset sequencer and button conditioner for the MAX1000 top.
- Sits between the PLL output clock / USER_BTN pin and the reset input of the SoC core (`dut`).
- Synchronises and debounces the raw push-button, and stretches reset for a fixed hold time after power-up and after every button release.
- Produces a clean, glitch-free, active-high reset plus a debounced button level and press counter for LED/debug use.

## Interface
Parameters:
- `DBNC_CYCLES`, 65536: consecutive stable cycles needed to accept a button level change (≥2).
- `HOLD_CYCLES`, 4096: reset stretch length in clocks after reset release or button release (≥1).

Ports:
- `clk`  in  1  system clock from PLL c0.
- `reset`  in  1  synchronous, active-low block reset (tie to PLL locked); sampled on the `clk` rising edge.
- `btn`  in  1  raw USER_BTN, asynchronous to `clk`; 0 = pressed, 1 = released.
- `rst_out`  out  1  active-high reset to the core; registered.
- `btn_db`  out  1  debounced button level; 1 = pressed; registered.
- `press_cnt`  out  8  count of accepted presses; wraps modulo 256.

## Operation
- Synchroniser: 2-FF chain on `~btn` gives `btn_s`. Both FFs reset to 0 (released).
- Debouncer:
  - Counter `dc` compares `btn_s` with `btn_db`.
  - Equal: `dc` <= 0.
  - Differ: `dc` increments. When `dc == DBNC_CYCLES-1`, `btn_db` <= `btn_s` and `dc` <= 0.
  - Any return to equality before then clears `dc`.
- `press_cnt` increments on the edge where `btn_db` goes 0→1; 255 wraps to 0.
- FSM states:
  - HOLD: `rst_out`=1.
    - Counter `hc` increments each cycle; at `hc == HOLD_CYCLES-1` → RUN.
    - If `btn_db`=1 → PRESSED (takes priority over the terminal count).
  - RUN: `rst_out`=0. `btn_db`=1 → PRESSED.
  - PRESSED: `rst_out`=1. `btn_db`=0 → HOLD with `hc` cleared.
- `rst_out` is registered from the next-state value. There are no combinational paths from `btn` to any output.
- Reset (`reset`=0), mid-operation included, on the next edge:
  - State = HOLD, `hc`=0, `dc`=0, sync FFs=0.
  - Outputs: `rst_out`=1, `btn_db`=0, `press_cnt`=0.
  - A button still held at reset release must be re-qualified through the full debounce before it counts.

## Timing
- Post-reset: with `btn` released, `rst_out` stays 1 and drops on the `HOLD_CYCLES`-th edge after the first edge that samples `reset`=1.
- Pin to `btn_db`: 2 (sync) + `DBNC_CYCLES` edges.
- `btn_db` rise to `rst_out` rise: 1 edge. `press_cnt` updates on the same edge as `rst_out`.
- `btn_db` fall to `rst_out` fall: `HOLD_CYCLES` edges (1 edge to re-enter HOLD + `HOLD_CYCLES`-1 counts), unless another press is accepted in between.
- `press_cnt` changes at most once per accepted press, never on release.

## Configuration
- `RESET_SEQ_DEBOUNCE_EN` defined:
  - Debouncer present as described.
- Undefined:
  - Debouncer removed; `btn_db` <= `btn_s` every cycle.
  - Pin-to-`btn_db` latency is 2 edges; `DBNC_CYCLES` is ignored.
  - FSM, hold stretch and `press_cnt` are unchanged.

## Test plan
Run with `DBNC_CYCLES`=8, `HOLD_CYCLES`=16 and the macro defined unless noted.
- Power-up: `reset`=0 for 5 cycles, then 1, `btn`=1 → `rst_out`=1 for exactly 16 edges, then 0 and stays 0; `btn_db`=0, `press_cnt`=0.
- Clean press in RUN: `btn`=0 for 30 cycles, then 1 →
  - `btn_db` rises 10 edges after the pin falls; `rst_out` rises 1 edge later; `press_cnt`=1.
  - `btn_db` falls 10 edges after the pin rises; `rst_out` falls 16 edges after that.
- Bounce: 5 pulses of `btn`=0 lasting 7 cycles each, separated by 3 cycles high → `btn_db`, `rst_out` and `press_cnt` stay 0/0/0.
- Press during HOLD (accepted at hold count 5) → immediately PRESSED, no RUN entry; after release, a full 16-cycle hold restarts from 0.
- `reset`=0 while in PRESSED with `btn` still 0 → next edge: `rst_out`=1, `btn_db`=0, `press_cnt`=0. After `reset`=1, `btn_db` re-rises after 10 edges and `press_cnt`=1.
- 256 accepted presses → `press_cnt` wraps to 0. Macro undefined, 3-cycle press → `btn_db` rises 2 edges after the pin falls, `press_cnt`=1.
